pll_cfg_sequencer: RTL and testbench

- Drives the control inputs of the digital PLL: resetb, enable, dco, div, ext_trim.
- Gives a glitch-free restart for every configuration change, holding the PLL in reset before re-enabling it.
- In DCO mode, ramps the 26-bit external trim one thermometer step at a time so the ring oscillator frequency never jumps.
- Sits between the register block (cfg_* inputs) and the PLL instance.

---
 rtl/pll_cfg_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pll_cfg_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_cfg_sequencer.sv
// Restart/ramp sequencer for the digital PLL control inputs.
// Each accepted start holds the PLL in reset for RESET_CYCLES, then enables it.
// In DCO mode the thermometer trim is ramped one bit every STEP_CYCLES.
// In FLL mode the block waits LOCK_CYCLES before reporting done.
module pll_cfg_sequencer #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned STEP_CYCLES  = 8,
    parameter int unsigned LOCK_CYCLES  = 1024
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic        cfg_dco,
    input  logic [4:0]  cfg_div,
    input  logic [4:0]  cfg_trim_cnt,
    output logic        pll_resetb,
    output logic        pll_enable,
    output logic        pll_dco,
    output logic [4:0]  pll_div,
    output logic [25:0] pll_ext_trim,
    output logic        busy,
    output logic        done
);

    localparam int unsigned TRIM_W  = 26;
    localparam int unsigned CNT_MAX =
        (RESET_CYCLES > STEP_CYCLES) ?
            ((RESET_CYCLES > LOCK_CYCLES) ? RESET_CYCLES : LOCK_CYCLES) :
            ((STEP_CYCLES > LOCK_CYCLES) ? STEP_CYCLES : LOCK_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [4:0]       TRIM_MAX   = 5'(TRIM_W);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_HOLD  = 3'd1,
        RAMP      = 3'd2,
        LOCK_WAIT = 3'd3,
        RUN       = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [4:0]       trim_cnt;
    logic [4:0]       trim_nxt;
    logic [4:0]       target;
    logic [4:0]       target_nxt;
    logic             dco_nxt;
    logic [4:0]       div_nxt;
    logic             start_ok;
    logic [4:0]       trim_clamped;

    // Thermometer code with the lowest n bits set.
    function automatic logic [TRIM_W-1:0] therm(input logic [4:0] n);
        logic [TRIM_W-1:0] t;
        t = '0;
        for (int i = 0; i < int'(TRIM_W); i++) begin
            t[i] = (5'(i) < n);
        end
        return t;
    endfunction

    // Start is honoured only when no sequence is running; stop has priority.
    assign start_ok     = cfg_start && !cfg_stop && ((state == IDLE) || (state == RUN));
    assign trim_clamped = (cfg_trim_cnt > TRIM_MAX) ? TRIM_MAX : cfg_trim_cnt;

    // Next-state, counter, trim and shadow-register logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        trim_nxt   = trim_cnt;
        target_nxt = target;
        dco_nxt    = pll_dco;
        div_nxt    = pll_div;

        if (cfg_stop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            trim_nxt  = '0;
        end else if (start_ok) begin
            state_nxt  = RST_HOLD;
            cnt_nxt    = '0;
            trim_nxt   = '0;
            target_nxt = trim_clamped;
            dco_nxt    = cfg_dco;
            div_nxt    = cfg_div;
        end else begin
            case (state)
                RST_HOLD: begin
                    if (cnt == RESET_LAST) begin
                        state_nxt = pll_dco ? RAMP : LOCK_WAIT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                RAMP: begin
                    if (trim_cnt == target) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else if (cnt == STEP_LAST) begin
                        trim_nxt = trim_cnt + 5'd1;
                        cnt_nxt  = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                LOCK_WAIT: begin
                    if (cnt == LOCK_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, counters and shadow registers.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            trim_cnt <= '0;
            target   <= '0;
            pll_dco  <= 1'b0;
            pll_div  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            trim_cnt <= trim_nxt;
            target   <= target_nxt;
            pll_dco  <= dco_nxt;
            pll_div  <= div_nxt;
        end
    end

    // Registered PLL controls and status, decoded from the next state.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            pll_resetb   <= 1'b0;
            pll_enable   <= 1'b0;
            pll_ext_trim <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            pll_resetb   <= (state_nxt == RAMP) || (state_nxt == LOCK_WAIT) || (state_nxt == RUN);
            pll_enable   <= (state_nxt == RAMP) || (state_nxt == LOCK_WAIT) || (state_nxt == RUN);
            pll_ext_trim <= therm(trim_nxt);
            busy         <= (state_nxt == RST_HOLD) || (state_nxt == RAMP) || (state_nxt == LOCK_WAIT);
            done         <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Scoreboard bench for pll_cfg_sequencer: a timeline model predicts every
// output transition (value and edge number); a monitor checks each change.
module tb_pll_cfg_sequencer;

    localparam int RC = 16;
    localparam int SC = 8;
    localparam int LC = 1024;

    logic        mclk;
    logic        reset_n;
    logic        cfg_start;
    logic        cfg_stop;
    logic        cfg_dco;
    logic [4:0]  cfg_div;
    logic [4:0]  cfg_trim_cnt;
    logic        pll_resetb;
    logic        pll_enable;
    logic        pll_dco;
    logic [4:0]  pll_div;
    logic [25:0] pll_ext_trim;
    logic        busy;
    logic        done;

    pll_cfg_sequencer #(
        .RESET_CYCLES (RC),
        .STEP_CYCLES  (SC),
        .LOCK_CYCLES  (LC)
    ) dut (
        .mclk         (mclk),
        .reset_n      (reset_n),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_dco      (cfg_dco),
        .cfg_div      (cfg_div),
        .cfg_trim_cnt (cfg_trim_cnt),
        .pll_resetb   (pll_resetb),
        .pll_enable   (pll_enable),
        .pll_dco      (pll_dco),
        .pll_div      (pll_div),
        .pll_ext_trim (pll_ext_trim),
        .busy         (busy),
        .done         (done)
    );

    // Output vector: {resetb, enable, dco, div[4:0], trim[25:0], busy, done}
    logic [35:0] dut_vec;
    assign dut_vec = {pll_resetb, pll_enable, pll_dco, pll_div, pll_ext_trim, busy, done};

    typedef struct {
        int          cyc;
        logic [35:0] v;
    } exp_t;

    exp_t        q[$];
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    logic [35:0] prev       = '0;
    logic [35:0] last_exp   = '0;

    // Reference model: a sequence is described by its accept edge and settings.
    bit          m_active = 1'b0;
    int          m_n0     = 0;
    int          m_t      = 0;
    bit          m_dco    = 1'b0;
    logic [4:0]  m_div    = '0;

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    always @(posedge mclk) cyc <= cyc + 1;

    function automatic int run_len();
        return m_dco ? (RC + SC * m_t + 1) : (RC + LC);
    endfunction

    function automatic bit busy_at(input int n);
        return m_active && ((n - m_n0) < run_len());
    endfunction

    function automatic logic [35:0] model_vec(input int n);
        int          k;
        int          tn;
        bit          on;
        bit          b;
        logic [26:0] th;
        if (!m_active) return {2'b00, m_dco, m_div, 26'd0, 2'b00};
        k  = n - m_n0;
        on = (k >= RC);
        b  = (k < run_len());
        tn = 0;
        if (m_dco && on) begin
            tn = (k - RC) / SC;
            if (tn > m_t) tn = m_t;
        end
        th = (27'd1 << tn) - 27'd1;
        return {on, on, m_dco, m_div, th[25:0], b, !b};
    endfunction

    task automatic push_if_changed(input int n);
        logic [35:0] v;
        exp_t        e;
        v = model_vec(n);
        if (v !== last_exp) begin
            e.cyc = n;
            e.v   = v;
            q.push_back(e);
            last_exp = v;
        end
    endtask

    // Advance the model to edge n with the inputs sampled there.
    task automatic model_edge(input int n, input bit st, input bit sp, input bit d,
                              input logic [4:0] dv, input logic [4:0] tc);
        if (!reset_n) begin
            m_active = 1'b0;
            m_dco    = 1'b0;
            m_div    = '0;
        end else if (sp) begin
            m_active = 1'b0;
        end else if (st && !busy_at(n - 1)) begin
            m_active = 1'b1;
            m_n0     = n;
            m_t      = (int'(tc) > 26) ? 26 : int'(tc);
            m_dco    = d;
            m_div    = dv;
        end
        push_if_changed(n);
    endtask

    task automatic step(input bit st, input bit sp, input bit d,
                        input logic [4:0] dv, input logic [4:0] tc);
        @(negedge mclk);
        cfg_start    = st;
        cfg_stop     = sp;
        cfg_dco      = d;
        cfg_div      = dv;
        cfg_trim_cnt = tc;
        model_edge(cyc + 1, st, sp, d, dv, tc);
    endtask

    // Idle cycles with random (ignored) configuration data.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic check_now(input string name, input logic [35:0] exp_v);
        vectors++;
        if (dut_vec !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, dut_vec, exp_v, cyc);
        end
    endtask

    // Assert reset between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        @(negedge mclk);
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        #2;
        reset_n  = 1'b0;
        m_active = 1'b0;
        m_dco    = 1'b0;
        m_div    = '0;
        push_if_changed(cyc + 1);
        #1;
        check_now("async_reset_clear", 36'd0);
    endtask

    task automatic release_reset();
        @(negedge mclk);
        reset_n   = 1'b1;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        model_edge(cyc + 1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0);
    endtask

    // Monitor: every observed output change must match the next prediction.
    always @(negedge mclk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_change: expected %h at cycle %0d, output stayed %h", e.v, e.cyc, dut_vec);
        end
        if (dut_vec !== prev) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_change: got %h (was %h) at cycle %0d, expected no change", dut_vec, prev, cyc);
            end else begin
                e = q.pop_front();
                if (e.v !== dut_vec || e.cyc != cyc) begin
                    miscompares++;
                    $display("FAIL transition: got %h at cycle %0d expected %h at cycle %0d", dut_vec, cyc, e.v, e.cyc);
                end
            end
            prev = dut_vec;
        end
    end

    initial begin
        reset_n      = 1'b0;
        cfg_start    = 1'b0;
        cfg_stop     = 1'b0;
        cfg_dco      = 1'b0;
        cfg_div      = '0;
        cfg_trim_cnt = '0;
        repeat (3) @(posedge mclk);
        #1;
        check_now("reset_state", 36'd0);
        release_reset();
        idle(4);

        // DCO ramp to 5
        step(1'b1, 1'b0, 1'b1, 5'd3, 5'd5);
        idle(RC + SC * 5 + 6);
        check_now("dco5_run", {2'b11, 1'b1, 5'd3, 26'h000001F, 2'b01});

        // FLL with div 8
        step(1'b1, 1'b0, 1'b0, 5'd8, 5'd0);
        idle(RC + LC + 4);
        check_now("fll_run", {2'b11, 1'b0, 5'd8, 26'h0, 2'b01});

        // Clamp of trim target 31 to 26
        step(1'b1, 1'b0, 1'b1, 5'd2, 5'd31);
        idle(RC + SC * 26 + 5);
        check_now("clamp_run", {2'b11, 1'b1, 5'd2, 26'h3FFFFFF, 2'b01});

        // Start during RAMP is ignored, start in RUN restarts
        step(1'b1, 1'b0, 1'b1, 5'd4, 5'd6);
        idle(30);
        step(1'b1, 1'b0, 1'b0, 5'd9, 5'd3);
        idle(40);
        step(1'b1, 1'b0, 1'b1, 5'd1, 5'd2);
        idle(RC + SC * 2 + 4);

        // Start and stop together in RUN: stop wins
        step(1'b1, 1'b1, 1'b0, 5'd17, 5'd4);
        idle(5);
        check_now("stop_wins", {2'b00, 1'b1, 5'd1, 26'h0, 2'b00});

        // Reset mid-ramp at trim 0x7
        step(1'b1, 1'b0, 1'b1, 5'd6, 5'd10);
        idle(RC + SC * 3 + 4);
        check_now("mid_ramp_trim", {2'b11, 1'b1, 5'd6, 26'h7, 2'b10});
        async_reset();
        idle(3);
        release_reset();
        idle(20);

        // Randomised traffic
        for (int i = 0; i < 20000; i++) begin
            int r;
            r = int'($urandom_range(0, 255));
            step(r < 4, r == 255, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)));
        end

        step(1'b0, 1'b1, 1'b0, 5'd0, 5'd0);
        idle(4);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expectations: got %0d left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
